// File: rtl/sbox_share_sched_if.sv
// ---------------------------------------------------------------------------
// sbox_share_sched_if
//   Bundle of the signals around the shared SubWord scheduler.
//   The round datapath uses the st_* group, key expansion uses the kw_* group,
//   and the shared 4-S-box unit uses sw_in/sw_out. busy reports scheduler
//   activity.
//
//   st_valid / st_ready / st_in   : SubBytes request handshake (128-bit state)
//   st_done  / st_out             : SubBytes completion pulse and result
//   kw_valid / kw_ready / kw_in   : SubWord request handshake (32-bit word)
//   kw_done  / kw_out             : SubWord completion pulse and result
//   sw_in    / sw_out             : operand to / combinational result from
//                                   the shared SubWord unit
//   busy                          : scheduler is not idle
//
//   Modports:
//     slave  - the scheduler itself
//     master - the surrounding core (requesters plus the shared S-box unit)
// ---------------------------------------------------------------------------
interface sbox_share_sched_if;
    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_in;
    logic         st_done;
    logic [127:0] st_out;

    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_in;
    logic         kw_done;
    logic [31:0]  kw_out;

    logic [31:0]  sw_in;
    logic [31:0]  sw_out;

    logic         busy;

    modport slave (
        input  st_valid, st_in, kw_valid, kw_in, sw_out,
        output st_ready, st_done, st_out, kw_ready, kw_done, kw_out, sw_in, busy
    );

    modport master (
        output st_valid, st_in, kw_valid, kw_in, sw_out,
        input  st_ready, st_done, st_out, kw_ready, kw_done, kw_out, sw_in, busy
    );
endinterface

// File: rtl/sbox_share_sched.sv
// ---------------------------------------------------------------------------
// sbox_share_sched
//   Time-multiplexes one shared combinational 32-bit SubWord unit between
//   the AES round datapath (full 128-bit SubBytes, one column per cycle over
//   four cycles) and key expansion (a single SubWord in one cycle).
//   Simultaneous requests are arbitrated round-robin; a pass in progress is
//   never preempted.
//
//   Ports:
//     clk  : system clock, all logic on the rising edge
//     rst  : synchronous active-high reset
//     bus  : sbox_share_sched_if.slave
//              st_valid/st_ready/st_in, st_done/st_out  (state SubBytes)
//              kw_valid/kw_ready/kw_in, kw_done/kw_out  (key SubWord)
//              sw_in -> shared unit, sw_out <- shared unit (same cycle)
//              busy : FSM not idle
//
//   Timing: state accepted in cycle T gives st_done in T+5; key word
//   accepted in T gives kw_done in T+2. The done cycle is an idle cycle, so
//   the next request may be accepted in it.
// ---------------------------------------------------------------------------
module sbox_share_sched (
    input  logic                  clk,
    input  logic                  rst,
    sbox_share_sched_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_PASS = 2'd1,
        KW_PASS = 2'd2
    } state_t;

    // Which requester was served most recently; the other one wins a tie.
    typedef enum logic {
        GRANT_KW = 1'b0,
        GRANT_ST = 1'b1
    } grant_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    grant_t       last_grant_q, last_grant_d;

    logic [127:0] st_buf_q, st_buf_d;
    logic [31:0]  kw_buf_q, kw_buf_d;

    logic [127:0] st_out_q, st_out_d;
    logic [31:0]  kw_out_q, kw_out_d;
    logic         st_done_q, st_done_d;
    logic         kw_done_q, kw_done_d;

    logic         st_ready_c;
    logic         kw_ready_c;
    logic [31:0]  sw_in_c;
    logic         grant_st_c;
    logic         grant_kw_c;

    // Column 0 is the most significant word of the state.
    function automatic logic [31:0] col_word(input logic [127:0] s,
                                             input logic [1:0]   c);
        logic [31:0] w;
        case (c)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] s,
                                              input logic [1:0]   c,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    // Round-robin tie break: with both requesters valid, the one that was
    // not served last time is granted. Out of reset last_grant is KW, so the
    // state side wins the first tie.
    always_comb begin
        grant_st_c = bus.st_valid && (!bus.kw_valid || (last_grant_q == GRANT_KW));
        grant_kw_c = bus.kw_valid && (!bus.st_valid || (last_grant_q == GRANT_ST));
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        last_grant_d = last_grant_q;
        st_buf_d     = st_buf_q;
        kw_buf_d     = kw_buf_q;
        st_out_d     = st_out_q;
        kw_out_d     = kw_out_q;
        st_done_d    = 1'b0;
        kw_done_d    = 1'b0;
        st_ready_c   = 1'b0;
        kw_ready_c   = 1'b0;
        sw_in_c      = 32'h0;

        case (state_q)
            IDLE: begin
                // Both readies are high here; only the granted side's
                // operand is captured, the loser simply keeps waiting.
                st_ready_c = 1'b1;
                kw_ready_c = 1'b1;
                if (grant_st_c) begin
                    st_buf_d = bus.st_in;
                    col_d    = 2'd0;
                    state_d  = ST_PASS;
                end else if (grant_kw_c) begin
                    kw_buf_d = bus.kw_in;
                    state_d  = KW_PASS;
                end
            end

            ST_PASS: begin
                // One column per cycle; st_out is updated word by word, so
                // partial results are visible before st_done.
                sw_in_c  = col_word(st_buf_q, col_q);
                st_out_d = put_word(st_out_q, col_q, bus.sw_out);
                if (col_q == 2'd3) begin
                    col_d        = 2'd0;
                    last_grant_d = GRANT_ST;
                    st_done_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end

            KW_PASS: begin
                sw_in_c      = kw_buf_q;
                kw_out_d     = bus.sw_out;
                last_grant_d = GRANT_KW;
                kw_done_d    = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and visible results. A reset mid-pass abandons the operation
    // and clears the results without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= 2'd0;
            last_grant_q <= GRANT_KW;
            st_out_q     <= 128'h0;
            kw_out_q     <= 32'h0;
            st_done_q    <= 1'b0;
            kw_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            last_grant_q <= last_grant_d;
            st_out_q     <= st_out_d;
            kw_out_q     <= kw_out_d;
            st_done_q    <= st_done_d;
            kw_done_q    <= kw_done_d;
        end
    end

    // Operand capture buffers: only read during a pass that loaded them,
    // so they need no reset.
    always_ff @(posedge clk) begin
        st_buf_q <= st_buf_d;
        kw_buf_q <= kw_buf_d;
    end

    assign bus.st_ready = st_ready_c;
    assign bus.kw_ready = kw_ready_c;
    assign bus.st_done  = st_done_q;
    assign bus.kw_done  = kw_done_q;
    assign bus.st_out   = st_out_q;
    assign bus.kw_out   = kw_out_q;
    assign bus.sw_in    = sw_in_c;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_sched.sv
module tb_sbox_share_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    sbox_share_sched_if bus();

    sbox_share_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] ST_VEC  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] ST_EXP  = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [31:0]  KW_VEC  = 32'hcf4f3c09;
    localparam logic [31:0]  KW_EXP  = 32'h8a84eb01;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Reference shared SubWord unit.
    always_comb bus.sw_out = sub_word(bus.sw_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.st_done !== 1'b0) $display("FAIL rst_st_done: got %b expected 0", bus.st_done); else n_pass++;
        n_checks++; if (bus.kw_done !== 1'b0) $display("FAIL rst_kw_done: got %b expected 0", bus.kw_done); else n_pass++;
        n_checks++; if (bus.st_out !== 128'h0) $display("FAIL rst_st_out: got %h expected 0", bus.st_out); else n_pass++;
        n_checks++; if (bus.kw_out !== 32'h0) $display("FAIL rst_kw_out: got %h expected 0", bus.kw_out); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy); else n_pass++;
        n_checks++; if (bus.sw_in !== 32'h0) $display("FAIL rst_sw_in: got %h expected 0", bus.sw_in); else n_pass++;
        n_checks++; if (bus.st_ready !== 1'b1 || bus.kw_ready !== 1'b1)
            $display("FAIL rst_ready: got st=%b kw=%b expected both 1", bus.st_ready, bus.kw_ready); else n_pass++;
    endtask

    task automatic test_state_pass();
        logic [31:0] cols [4];
        cols[0] = 32'h00102030; cols[1] = 32'h40506070;
        cols[2] = 32'h8090a0b0; cols[3] = 32'hc0d0e0f0;
        bus.st_in    = ST_VEC;
        bus.st_valid = 1'b1;
        n_checks++; if (bus.st_ready !== 1'b1) $display("FAIL st_accept_ready: got %b expected 1", bus.st_ready); else n_pass++;
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.st_in    = 128'h0;
        n_checks++; if (bus.st_ready !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL st_pass_flags: got ready=%b busy=%b expected 0/1", bus.st_ready, bus.busy); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge clk);
            n_checks++; if (bus.sw_in !== cols[k]) $display("FAIL st_sw_in_col%0d: got %h expected %h", k, bus.sw_in, cols[k]); else n_pass++;
            n_checks++; if (bus.st_done !== 1'b0) $display("FAIL st_done_early%0d: got %b expected 0", k, bus.st_done); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (bus.st_done !== 1'b1) $display("FAIL st_done_t5: got %b expected 1", bus.st_done); else n_pass++;
        n_checks++; if (bus.st_out !== ST_EXP) $display("FAIL st_out: got %h expected %h", bus.st_out, ST_EXP); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL st_done_busy: got %b expected 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.st_done !== 1'b0) $display("FAIL st_done_pulse: got %b expected 0", bus.st_done); else n_pass++;
        n_checks++; if (bus.st_out !== ST_EXP) $display("FAIL st_out_hold: got %h expected %h", bus.st_out, ST_EXP); else n_pass++;
    endtask

    task automatic test_key_pass();
        bus.kw_in    = KW_VEC;
        bus.kw_valid = 1'b1;
        n_checks++; if (bus.kw_ready !== 1'b1) $display("FAIL kw_accept_ready: got %b expected 1", bus.kw_ready); else n_pass++;
        @(negedge clk);
        bus.kw_valid = 1'b0;
        bus.kw_in    = 32'h0;
        n_checks++; if (bus.sw_in !== KW_VEC) $display("FAIL kw_sw_in: got %h expected %h", bus.sw_in, KW_VEC); else n_pass++;
        n_checks++; if (bus.kw_done !== 1'b0) $display("FAIL kw_done_early: got %b expected 0", bus.kw_done); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.kw_done !== 1'b1) $display("FAIL kw_done_t2: got %b expected 1", bus.kw_done); else n_pass++;
        n_checks++; if (bus.kw_out !== KW_EXP) $display("FAIL kw_out: got %h expected %h", bus.kw_out, KW_EXP); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL kw_done_busy: got %b expected 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.kw_done !== 1'b0) $display("FAIL kw_done_pulse: got %b expected 0", bus.kw_done); else n_pass++;
    endtask

    task automatic test_arbitration();
        bus.st_in    = ST_VEC;
        bus.kw_in    = KW_VEC;
        bus.st_valid = 1'b1;
        bus.kw_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // cycle 0: idle with both valid -> state side granted
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            case (c)
                1: begin n_checks++; if (bus.sw_in !== 32'h00102030) $display("FAIL arb_grant1_st: got %h expected 00102030", bus.sw_in); else n_pass++; end
                5: begin
                    n_checks++; if (bus.st_done !== 1'b1) $display("FAIL arb_st_done1: got %b expected 1", bus.st_done); else n_pass++;
                    n_checks++; if (bus.st_out !== ST_EXP) $display("FAIL arb_st_out: got %h expected %h", bus.st_out, ST_EXP); else n_pass++;
                end
                6: begin n_checks++; if (bus.sw_in !== KW_VEC) $display("FAIL arb_grant2_kw: got %h expected %h", bus.sw_in, KW_VEC); else n_pass++; end
                7: begin
                    n_checks++; if (bus.kw_done !== 1'b1) $display("FAIL arb_kw_done1: got %b expected 1", bus.kw_done); else n_pass++;
                    n_checks++; if (bus.kw_out !== KW_EXP) $display("FAIL arb_kw_out: got %h expected %h", bus.kw_out, KW_EXP); else n_pass++;
                end
                8:  begin n_checks++; if (bus.sw_in !== 32'h00102030) $display("FAIL arb_grant3_st: got %h expected 00102030", bus.sw_in); else n_pass++; end
                12: begin n_checks++; if (bus.st_done !== 1'b1) $display("FAIL arb_st_done2: got %b expected 1", bus.st_done); else n_pass++; end
                13: begin n_checks++; if (bus.sw_in !== KW_VEC) $display("FAIL arb_grant4_kw: got %h expected %h", bus.sw_in, KW_VEC); else n_pass++; end
                14: begin
                    n_checks++; if (bus.kw_done !== 1'b1) $display("FAIL arb_kw_done2: got %b expected 1", bus.kw_done); else n_pass++;
                    bus.st_valid = 1'b0;
                    bus.kw_valid = 1'b0;
                end
                default: ;
            endcase
        end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL arb_idle_after: got %b expected 0", bus.busy); else n_pass++;
    endtask

    task automatic test_kw_wait();
        bus.st_in    = ST_VEC;
        bus.st_valid = 1'b1;
        @(negedge clk);
        bus.st_valid = 1'b0;
        bus.kw_in    = 32'h00102030;
        bus.kw_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c != 1) @(negedge clk);
            n_checks++; if (bus.kw_ready !== 1'b0) $display("FAIL wait_kw_ready_t%0d: got %b expected 0", c, bus.kw_ready); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (bus.kw_ready !== 1'b1 || bus.st_done !== 1'b1)
            $display("FAIL wait_done_cycle: got kw_ready=%b st_done=%b expected 1/1", bus.kw_ready, bus.st_done); else n_pass++;
        @(negedge clk);
        bus.kw_valid = 1'b0;
        n_checks++; if (bus.sw_in !== 32'h00102030) $display("FAIL wait_kw_sw_in: got %h expected 00102030", bus.sw_in); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.kw_done !== 1'b1) $display("FAIL wait_kw_done: got %b expected 1", bus.kw_done); else n_pass++;
        n_checks++; if (bus.kw_out !== 32'h63cab704) $display("FAIL wait_kw_out: got %h expected 63cab704", bus.kw_out); else n_pass++;
        n_checks++; if (bus.st_out !== ST_EXP) $display("FAIL wait_st_out_kept: got %h expected %h", bus.st_out, ST_EXP); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pass();
        bus.st_in    = ST_VEC;
        bus.st_valid = 1'b1;
        @(negedge clk);
        bus.st_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.sw_in !== 32'h8090a0b0) $display("FAIL mid_col2: got %h expected 8090a0b0", bus.sw_in); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.st_out !== 128'h0) $display("FAIL mid_st_out_clr: got %h expected 0", bus.st_out); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.st_ready !== 1'b1)
            $display("FAIL mid_idle: got busy=%b ready=%b expected 0/1", bus.busy, bus.st_ready); else n_pass++;
        n_checks++; if (bus.kw_out !== 32'h0) $display("FAIL mid_kw_out_clr: got %h expected 0", bus.kw_out); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (bus.st_done !== 1'b0) $display("FAIL mid_no_done%0d: got %b expected 0", c, bus.st_done); else n_pass++;
            @(negedge clk);
        end
        bus.st_in    = 128'h0;
        bus.st_valid = 1'b1;
        @(negedge clk);
        bus.st_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.st_done !== 1'b1) $display("FAIL mid_new_done: got %b expected 1", bus.st_done); else n_pass++;
        n_checks++; if (bus.st_out !== {16{8'h63}}) $display("FAIL mid_new_st_out: got %h expected %h", bus.st_out, {16{8'h63}}); else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.st_valid = 1'b0;
        bus.kw_valid = 1'b0;
        bus.st_in    = 128'h0;
        bus.kw_in    = 32'h0;
        @(negedge clk);
        test_reset();
        test_state_pass();
        test_key_pass();
        test_arbitration();
        test_kw_wait();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
